tx_link_scheduler: RTL and testbench

//   Sequences the 8b/10b encoder (encode_8b10b) on the fibre TX path and shares it

---
 rtl/tx_link_scheduler.sv | 130 +++++++++++++
 tb/tb_tx_link_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: shares one 8b/10b encoder between two byte sources.
// One word slot lasts WORD_BITS clocks. Each slot is decided in the cycle
// bit_cnt==WORD_BITS-2, registered at that edge, and strobed to the encoder
// in the cycle that follows. Bursts are framed with a header byte. A forced
// idle word after SYNC_INTERVAL consecutive non-idle words keeps the far end
// comma-aligned.
module tx_link_scheduler #(
  parameter int          WORD_BITS     = 10,
  parameter int          MAX_BURST     = 16,
  parameter int          SYNC_INTERVAL = 64,
  parameter logic [7:0]  HDR_A         = 8'hF0,
  parameter logic [7:0]  HDR_B         = 8'hF1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       enc_nextword_enable,
  output logic       enc_idle,
  output logic [7:0] enc_d,
  output logic       cur_chan
);

  localparam int BW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(SYNC_INTERVAL + 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] burst_cnt, burst_nx;
  logic [SW-1:0] sync_cnt, sync_nx;
  logic          last_srv, last_nx;   // 0 = A, 1 = B
  logic          chan_nx, idle_nx;
  logic [7:0]    d_nx;
  logic          take_a, take_b;
  logic          dec, gnt_valid, win, other_valid, any_valid;

  assign dec         = (bit_cnt == BW'(WORD_BITS - 2));
  assign gnt_valid   = cur_chan ? b_valid : a_valid;
  // Round robin: on a tie the source not served last wins.
  assign win         = (a_valid && b_valid) ? ~last_srv : b_valid;
  assign other_valid = win ? a_valid : b_valid;
  assign any_valid   = a_valid | b_valid;

  // Ready only in the decision cycle of a data slot; reset kills a pending word.
  assign a_ready = rst_n & dec & take_a;
  assign b_ready = rst_n & dec & take_b;

  // Slot decision: what the next word is and how the grant state moves.
  always_comb begin
    state_nx = state;
    burst_nx = burst_cnt;
    sync_nx  = sync_cnt;
    last_nx  = last_srv;
    chan_nx  = cur_chan;
    idle_nx  = 1'b1;
    d_nx     = 8'h00;
    take_a   = 1'b0;
    take_b   = 1'b0;
    if (sync_cnt == SW'(SYNC_INTERVAL)) begin
      // Forced comma-alignment idle; the grant is dropped.
      state_nx = IDLE;
      sync_nx  = '0;
    end else if (state == DATA && gnt_valid && burst_cnt < CW'(MAX_BURST)) begin
      idle_nx  = 1'b0;
      d_nx     = cur_chan ? b_data : a_data;
      take_a   = ~cur_chan;
      take_b   = cur_chan;
      burst_nx = burst_cnt + CW'(1);
      sync_nx  = sync_cnt + SW'(1);
    end else if (any_valid) begin
      idle_nx = 1'b0;
      sync_nx = sync_cnt + SW'(1);
      if (state == DATA && win == cur_chan && !other_valid) begin
        // Same source keeps the link with nobody waiting: no new header.
        d_nx     = cur_chan ? b_data : a_data;
        take_a   = ~cur_chan;
        take_b   = cur_chan;
        burst_nx = CW'(1);
      end else begin
        d_nx     = win ? HDR_B : HDR_A;
        chan_nx  = win;
        last_nx  = win;
        state_nx = DATA;
        burst_nx = '0;
      end
    end else begin
      state_nx = IDLE;
      sync_nx  = '0;
    end
  end

  // Grant state register, advanced only at decision edges.
  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (dec) state <= state_nx;
  end

  // Bit counter, encoder outputs and slot bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt             <= '0;
      enc_nextword_enable <= 1'b0;
      enc_idle            <= 1'b1;
      enc_d               <= 8'h00;
      cur_chan            <= 1'b0;
      last_srv            <= 1'b1;
      burst_cnt           <= '0;
      sync_cnt            <= '0;
    end else begin
      bit_cnt             <= (bit_cnt == BW'(WORD_BITS - 1)) ? '0 : bit_cnt + BW'(1);
      enc_nextword_enable <= dec;
      if (dec) begin
        enc_idle  <= idle_nx;
        enc_d     <= d_nx;
        cur_chan  <= chan_nx;
        last_srv  <= last_nx;
        burst_cnt <= burst_nx;
        sync_cnt  <= sync_nx;
      end
    end
  end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler: a default instance plus one with
// SYNC_INTERVAL=8 to exercise the forced idle word quickly.
module tb_tx_link_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, a_valid, b_valid, a_ready, b_ready, nwe, enc_idle, cur_chan;
  logic [7:0] a_data, b_data, enc_d;
  logic       a8_valid, a8_ready, b8_ready, nwe8, idle8, chan8, zero8;
  logic [7:0] a8_data, d8, zd8;

  int         tests = 0, fails = 0;
  logic [8:0] w8;
  int         r8;

  localparam logic [8:0] IDL = 9'h100;
  localparam logic [8:0] HA  = 9'h0F0;
  localparam logic [8:0] HB  = 9'h0F1;

  tx_link_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .enc_nextword_enable(nwe), .enc_idle(enc_idle), .enc_d(enc_d),
    .cur_chan(cur_chan));

  tx_link_scheduler #(.SYNC_INTERVAL(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a8_valid), .a_data(a8_data), .a_ready(a8_ready),
    .b_valid(zero8), .b_data(zd8), .b_ready(b8_ready),
    .enc_nextword_enable(nwe8), .enc_idle(idle8), .enc_d(d8),
    .cur_chan(chan8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run up to and including the next strobe cycle; sources advance on transfer.
  task automatic next_slot(output logic [8:0] w, output int na, output int nb, output int cyc);
    logic ra, rb, rc, st;
    int   k8;
    na = 0; nb = 0; cyc = 0; k8 = 0; st = 1'b0; w = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ra = a_ready; rb = b_ready; rc = a8_ready; st = nwe;
      if (ra) na++;
      if (rb) nb++;
      if (rc) k8++;
      cyc++;
      w  = {enc_idle, enc_d};
      w8 = {idle8, d8};
      @(posedge clk); #1;
      if (ra) a_data++;
      if (rb) b_data++;
      if (rc) a8_data++;
      if (st) break;
    end
    r8 = k8;
    check("strobe_seen", {31'd0, st}, 32'd1);
  endtask

  task automatic slot(input string tag, input logic [8:0] ew, input int ena, input int enb);
    logic [8:0] w;
    int na, nb, c;
    next_slot(w, na, nb, c);
    check({tag, "_word"}, {23'd0, w}, {23'd0, ew});
    check({tag, "_rdy"}, na * 16 + nb, ena * 16 + enb);
  endtask

  initial begin
    logic [8:0] w;
    int na, nb, c;
    rst_n = 1'b0; a_valid = 0; b_valid = 0; a_data = 8'h00; b_data = 8'h80;
    a8_valid = 0; a8_data = 8'h00; zero8 = 1'b0; zd8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nwe", {31'd0, nwe}, 0);
    check("rst_idle", {31'd0, enc_idle}, 1);
    check("rst_d", {24'd0, enc_d}, 0);
    check("rst_chan", {31'd0, cur_chan}, 0);
    check("rst_rdy", {30'd0, a_ready, b_ready}, 0);
    rst_n = 1'b1;

    // 1: no traffic, idle words every 10 clocks
    for (int i = 0; i < 3; i++) begin
      next_slot(w, na, nb, c);
      check("t1_cyc", c, 10);
      check("t1_word", {23'd0, w}, {23'd0, IDL});
      check("t1_rdy", na + nb, 0);
    end

    // 4: SYNC_INTERVAL=8 instance, A continuous
    a8_valid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      next_slot(w, na, nb, c);
      check("t4_hdr", {23'd0, w8}, {23'd0, HA});
      check("t4_hdr_rdy", r8, 0);
      for (int i = 0; i < 7; i++) begin
        next_slot(w, na, nb, c);
        check("t4_byte", {23'd0, w8}, {23'd0, 1'b0, 8'(r * 7 + i)});
        check("t4_byte_rdy", r8, 1);
      end
      next_slot(w, na, nb, c);
      check("t4_sync_idle", {23'd0, w8}, {23'd0, IDL});
      check("t4_idle_rdy", r8, 0);
    end
    a8_valid = 1'b0;

    // 2: A alone; after 16 bytes it keeps the link without a new header
    a_valid = 1'b1; a_data = 8'h00;
    slot("t2_hdr", HA, 0, 0);
    check("t2_chan", {31'd0, cur_chan}, 0);
    for (int i = 0; i < 16; i++) slot("t2_byte", {1'b0, 8'(i)}, 1, 0);
    slot("t2_cont", 9'h010, 1, 0);
    a_valid = 1'b0;
    slot("t2_idle", IDL, 0, 0);

    // 3: both sources continuously; A was served last so B opens
    a_valid = 1'b1; b_valid = 1'b1;
    slot("t3_hb1", HB, 0, 0);
    check("t3_chan1", {31'd0, cur_chan}, 1);
    for (int i = 0; i < 16; i++) slot("t3_b1", {1'b0, 8'(8'h80 + i)}, 0, 1);
    slot("t3_ha", HA, 0, 0);
    check("t3_chan2", {31'd0, cur_chan}, 0);
    for (int i = 0; i < 16; i++) slot("t3_a", {1'b0, 8'(8'h11 + i)}, 1, 0);
    slot("t3_hb2", HB, 0, 0);
    check("t3_chan3", {31'd0, cur_chan}, 1);
    for (int i = 0; i < 16; i++) slot("t3_b2", {1'b0, 8'(8'h90 + i)}, 0, 1);
    slot("t3_ha2", HA, 0, 0);
    check("t3_chan4", {31'd0, cur_chan}, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    slot("t3_idle", IDL, 0, 0);

    // 5: B burst with a 3-slot gap after 5 bytes
    b_valid = 1'b1; b_data = 8'hA0;
    slot("t5_hdr", HB, 0, 0);
    for (int i = 0; i < 5; i++) slot("t5_b", {1'b0, 8'(8'hA0 + i)}, 0, 1);
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) slot("t5_gap", IDL, 0, 0);
    b_valid = 1'b1;
    slot("t5_rehdr", HB, 0, 0);
    slot("t5_b5", 9'h0A5, 0, 1);
    slot("t5_b6", 9'h0A6, 0, 1);
    b_valid = 1'b0;

    // 6: reset in the decision cycle of an A data slot
    a_valid = 1'b1; a_data = 8'h21;
    slot("t6_hdr", HA, 0, 0);
    slot("t6_b0", 9'h021, 1, 0);
    slot("t6_b1", 9'h022, 1, 0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_no_ready", {31'd0, a_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("t6_rst_nwe", {31'd0, nwe}, 0);
    check("t6_rst_idle", {31'd0, enc_idle}, 1);
    check("t6_rst_d", {24'd0, enc_d}, 0);
    next_slot(w, na, nb, c);
    check("t6_cyc", c, 10);
    check("t6_first_hdr", {23'd0, w}, {23'd0, HA});
    check("t6_hdr_rdy", na, 0);
    slot("t6_b2", 9'h023, 1, 0);
    slot("t6_b3", 9'h024, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
